// File: rtl/nes_joypad_responder_if.sv
// nes_joypad_responder_if: NES joypad serial bus (host strobe/clock, pad data).
// Rev 1.0
`default_nettype none

interface nes_joypad_responder_if;
  logic joy_strobe;
  logic joy_clock;
  logic joy_data;

  modport master (output joy_strobe, output joy_clock, input joy_data);
  modport slave  (input joy_strobe, input joy_clock, output joy_data);
endinterface

`default_nettype wire

// File: rtl/nes_joypad_responder.sv
// nes_joypad_responder: NES controller device end; latches buttons on strobe, shifts them out active-low.
// Rev 1.0
`default_nettype none

module nes_joypad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  buttons,
  nes_joypad_responder_if.slave       joy,
  output logic                        read_done,
  output logic [3:0]                  bit_index,
  output logic [7:0]                  read_count
);

  localparam int c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {joy.joy_clock, joy.joy_strobe};

  // Index 0 conditions strobe, index 1 conditions the shift clock.
  for (genvar g = 0; g < 2; g++) begin : g_cond
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        if (r_sync[SYNC_STAGES-1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_level <= r_sync[SYNC_STAGES-1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_filt[g] = r_level;
  end

  logic       w_stb_f;
  logic       w_clk_f;
  logic       w_shift;
  logic       r_clk_prev;
  logic [7:0] r_sr;

  assign w_stb_f = w_filt[0];
  assign w_clk_f = w_filt[1];
  assign w_shift = w_clk_f & ~r_clk_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_prev <= 1'b0;
      r_sr       <= 8'hFF;
      bit_index  <= 4'd8;
      read_done  <= 1'b0;
      read_count <= 8'd0;
    end else begin
      r_clk_prev <= w_clk_f;
      read_done  <= 1'b0;
      // Strobe holds the pad in load; a coincident clock edge is dropped.
      if (w_stb_f) begin
        r_sr      <= ~buttons;
        bit_index <= 4'd0;
      end else if (w_shift) begin
        r_sr <= {1'b1, r_sr[7:1]};
        if (bit_index < 4'd8) begin
          bit_index <= bit_index + 4'd1;
        end
        if (bit_index == 4'd7) begin
          read_done  <= 1'b1;
          read_count <= read_count + 8'd1;
        end
      end
    end
  end

  assign joy.joy_data = r_sr[0];

endmodule

`default_nettype wire

// File: tb/tb_nes_joypad_responder.sv
// tb_nes_joypad_responder: host-level scoreboard bench for the NES joypad responder.
// Rev 1.0
`default_nettype none

module tb_nes_joypad_responder;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       read_done;
  logic [3:0] bit_index;
  logic [7:0] read_count;

  always #5 clock = ~clock;

  nes_joypad_responder_if jif ();

  nes_joypad_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .buttons    (buttons),
    .joy        (jif.slave),
    .read_done  (read_done),
    .bit_index  (bit_index),
    .read_count (read_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  logic [7:0] m_sr   = 8'hFF;
  int         m_idx  = 8;
  logic [7:0] m_cnt  = 8'd0;
  int         m_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // read_done must coincide with bit_index reaching 8.
  always @(negedge clock) begin
    if (read_done === 1'b1) begin
      done_seen++;
      check("done_idx", 32'(bit_index), 32'd8);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_state();
    sb.push_back('{"joy_data",   32'(m_sr[0])});
    sb.push_back('{"bit_index",  32'(m_idx)});
    sb.push_back('{"read_count", 32'(m_cnt)});
    sb.push_back('{"done_count", 32'(m_done)});
  endtask

  task automatic score();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] obs;
      e = sb.pop_front();
      case (e.tag)
        "joy_data":   obs = 32'(jif.joy_data);
        "bit_index":  obs = 32'(bit_index);
        "read_count": obs = 32'(read_count);
        "done_count": obs = 32'(done_seen);
        default:      obs = 'x;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic do_strobe(input logic [7:0] b, input bit chk);
    buttons = b;
    jif.joy_strobe = 1'b1;
    m_sr  = ~b;
    m_idx = 0;
    if (chk) expect_state();
    tick(20);
    if (chk) score();
    jif.joy_strobe = 1'b0;
    tick(10);
  endtask

  task automatic do_pulse(input bit chk);
    m_sr = {1'b1, m_sr[7:1]};
    if (m_idx < 8) begin
      m_idx++;
      if (m_idx == 8) begin
        m_cnt = m_cnt + 8'd1;
        m_done++;
      end
    end
    if (chk) expect_state();
    jif.joy_clock = 1'b1;
    tick(10);
    jif.joy_clock = 1'b0;
    tick(10);
    if (chk) score();
  endtask

  initial begin
    jif.joy_strobe = 1'b0;
    jif.joy_clock  = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    expect_state();
    tick(1);
    score();

    // Single A press: only bit0 low.
    do_strobe(8'h01, 1'b1);
    for (int i = 0; i < 8; i++) do_pulse(1'b1);

    // Mixed pattern plus two fill shifts.
    do_strobe(8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) do_pulse(1'b1);

    // Buttons change after latch are ignored until the next strobe.
    do_strobe(8'hFF, 1'b1);
    buttons = 8'h00;
    for (int i = 0; i < 8; i++) do_pulse(1'b1);
    do_strobe(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) do_pulse(1'b1);

    // Short clock glitch is filtered out, a legal pulse shifts once.
    do_strobe(8'h5A, 1'b1);
    jif.joy_clock = 1'b1;
    tick(FILTER_LEN - 1);
    jif.joy_clock = 1'b0;
    tick(12);
    expect_state();
    score();
    jif.joy_clock = 1'b1;
    m_sr = {1'b1, m_sr[7:1]};
    m_idx++;
    expect_state();
    tick(FILTER_LEN + 2);
    jif.joy_clock = 1'b0;
    tick(12);
    score();

    // Strobe mid-read aborts; a full read afterwards counts exactly once.
    do_strobe(8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) do_pulse(1'b1);
    do_strobe(8'hC3, 1'b1);
    for (int i = 0; i < 8; i++) do_pulse(1'b1);

    // Reset mid-read.
    do_strobe(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) do_pulse(1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_sr  = 8'hFF;
    m_idx = 8;
    m_cnt = 8'd0;
    expect_state();
    score();

    // 256 full reads wrap the read counter back to 0.
    for (int r = 0; r < 256; r++) begin
      do_strobe(8'h3C, 1'b0);
      for (int i = 0; i < 8; i++) do_pulse(1'b0);
    end
    expect_state();
    score();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
